// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB over a shared
// variable-latency memory, with memory timeout, illegal-opcode trap and retire counter.
module multicycle_ctrl #(
  parameter int ALUOP_W     = 6,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               EXTOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         NPCOp,
  output logic               ALUSrc,
  output logic [1:0]         GPRSel,
  output logic [1:0]         WDSel,
  output logic [2:0]         state,
  output logic               illegal,
  output logic               bus_err,
  output logic [CNT_W-1:0]   instr_cnt
);

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5;

  localparam logic [ALUOP_W-1:0] ALU_NOP  = ALUOP_W'(0),  ALU_ADD  = ALUOP_W'(1),
                                 ALU_SUB  = ALUOP_W'(2),  ALU_AND  = ALUOP_W'(3),
                                 ALU_OR   = ALUOP_W'(4),  ALU_SLT  = ALUOP_W'(5),
                                 ALU_SLTU = ALUOP_W'(6),  ALU_XOR  = ALUOP_W'(7),
                                 ALU_NOR  = ALUOP_W'(8),  ALU_SLL  = ALUOP_W'(9),
                                 ALU_SRL  = ALUOP_W'(10), ALU_SLLV = ALUOP_W'(11),
                                 ALU_SRLV = ALUOP_W'(12), ALU_SRAV = ALUOP_W'(13),
                                 ALU_LUI  = ALUOP_W'(14), ALU_BGEZ = ALUOP_W'(15),
                                 ALU_BGTZ = ALUOP_W'(16), ALU_SRA  = ALUOP_W'(17);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  logic [WCW-1:0]     wait_cnt;
  logic [2:0]         next_state;
  logic               timeout;

  logic               d_legal, d_asrc, d_ext, d_load, d_store, d_branch, d_taken;
  logic               d_jr, d_jump, d_link, d_itype;
  logic [ALUOP_W-1:0] d_alu;

  // Instruction decode; only consumed from DECODE onwards where Op/Funct are stable.
  always_comb begin
    d_legal = 1'b0; d_asrc = 1'b0; d_ext = 1'b0; d_load = 1'b0; d_store = 1'b0;
    d_branch = 1'b0; d_taken = 1'b0; d_jr = 1'b0; d_jump = 1'b0; d_link = 1'b0;
    d_itype = 1'b0; d_alu = ALU_NOP;
    case (Op)
      6'h00: begin
        d_legal = 1'b1;
        case (Funct)
          6'h20, 6'h21: d_alu = ALU_ADD;
          6'h22, 6'h23: d_alu = ALU_SUB;
          6'h24: d_alu = ALU_AND;
          6'h25: d_alu = ALU_OR;
          6'h26: d_alu = ALU_XOR;
          6'h27: d_alu = ALU_NOR;
          6'h2A: d_alu = ALU_SLT;
          6'h2B: d_alu = ALU_SLTU;
          6'h00: begin d_alu = ALU_SLL; d_asrc = 1'b1; end
          6'h02: begin d_alu = ALU_SRL; d_asrc = 1'b1; end
          6'h03: begin d_alu = ALU_SRA; d_asrc = 1'b1; end
          6'h04: d_alu = ALU_SLLV;
          6'h06: d_alu = ALU_SRLV;
          6'h07: d_alu = ALU_SRAV;
          6'h08: d_jr = 1'b1;
          6'h09: begin d_jr = 1'b1; d_link = 1'b1; end
          default: d_legal = 1'b0;
        endcase
      end
      // Zero is the ALU result-is-zero flag; BGTZ's result is 0 exactly when rs <= 0.
      6'h01: begin d_legal = 1'b1; d_branch = 1'b1; d_alu = ALU_BGEZ; d_taken = ~Zero; end
      6'h04: begin d_legal = 1'b1; d_branch = 1'b1; d_alu = ALU_SUB;  d_taken = Zero;  end
      6'h05: begin d_legal = 1'b1; d_branch = 1'b1; d_alu = ALU_SUB;  d_taken = ~Zero; end
      6'h06: begin d_legal = 1'b1; d_branch = 1'b1; d_alu = ALU_BGTZ; d_taken = Zero;  end
      6'h07: begin d_legal = 1'b1; d_branch = 1'b1; d_alu = ALU_BGTZ; d_taken = ~Zero; end
      6'h02: begin d_legal = 1'b1; d_jump = 1'b1; end
      6'h03: begin d_legal = 1'b1; d_jump = 1'b1; d_link = 1'b1; end
      6'h08, 6'h09: begin d_legal = 1'b1; d_itype = 1'b1; d_asrc = 1'b1; d_ext = 1'b1; d_alu = ALU_ADD; end
      6'h0A: begin d_legal = 1'b1; d_itype = 1'b1; d_asrc = 1'b1; d_ext = 1'b1; d_alu = ALU_SLT;  end
      6'h0B: begin d_legal = 1'b1; d_itype = 1'b1; d_asrc = 1'b1; d_ext = 1'b1; d_alu = ALU_SLTU; end
      6'h0C: begin d_legal = 1'b1; d_itype = 1'b1; d_asrc = 1'b1; d_alu = ALU_AND; end
      6'h0D: begin d_legal = 1'b1; d_itype = 1'b1; d_asrc = 1'b1; d_alu = ALU_OR;  end
      6'h0E: begin d_legal = 1'b1; d_itype = 1'b1; d_asrc = 1'b1; d_alu = ALU_XOR; end
      6'h0F: begin d_legal = 1'b1; d_itype = 1'b1; d_asrc = 1'b1; d_alu = ALU_LUI; end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        d_legal = 1'b1; d_load = 1'b1; d_itype = 1'b1; d_asrc = 1'b1; d_ext = 1'b1; d_alu = ALU_ADD;
      end
      6'h28, 6'h29, 6'h2B: begin
        d_legal = 1'b1; d_store = 1'b1; d_asrc = 1'b1; d_ext = 1'b1; d_alu = ALU_ADD;
      end
      default: d_legal = 1'b0;
    endcase
  end

  // Memory handshake: MemRead/MemWrite stay high until mem_ready=1 in the same cycle,
  // which completes the access; mem_ready is ignored in every other state.
  always_comb begin
    PCWrite = 1'b0; IRWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0;
    EXTOp = 1'b0; ALUOp = ALU_NOP; NPCOp = 2'b00; ALUSrc = 1'b0; GPRSel = 2'b00;
    WDSel = 2'b00; next_state = state; timeout = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          if (mem_ready) begin
            IRWrite = 1'b1; PCWrite = 1'b1; next_state = S_DECODE;
          end else if (wait_cnt == WCW'(MEM_TIMEOUT)) begin
            timeout = 1'b1; next_state = S_TRAP;
          end
        end
        S_DECODE: begin
          if (!d_legal) next_state = S_TRAP;
          else if (d_jump) begin
            PCWrite = 1'b1; NPCOp = 2'b10; next_state = S_FETCH;
            if (d_link) begin RegWrite = 1'b1; GPRSel = 2'b10; WDSel = 2'b10; end
          end else next_state = S_EXEC;
        end
        S_EXEC: begin
          ALUOp = d_alu; ALUSrc = d_asrc; EXTOp = d_ext;
          if (d_branch) begin
            PCWrite = d_taken; NPCOp = 2'b01; next_state = S_FETCH;
          end else if (d_jr) begin
            PCWrite = 1'b1; NPCOp = 2'b11; next_state = S_FETCH;
            if (d_link) begin RegWrite = 1'b1; GPRSel = 2'b10; WDSel = 2'b10; end
          end else if (d_load || d_store) next_state = S_MEM;
          else next_state = S_WB;
        end
        S_MEM: begin
          MemRead = d_load; MemWrite = d_store;
          if (mem_ready) next_state = d_store ? S_FETCH : S_WB;
          else if (wait_cnt == WCW'(MEM_TIMEOUT)) begin
            timeout = 1'b1; next_state = S_TRAP;
          end
        end
        S_WB: begin
          RegWrite = 1'b1; WDSel = d_load ? 2'b01 : 2'b00; GPRSel = d_itype ? 2'b01 : 2'b00;
          next_state = S_FETCH;
        end
        S_TRAP: next_state = S_TRAP;
        default: next_state = S_TRAP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      instr_cnt <= '0;
      illegal   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == S_FETCH || state == S_MEM) && next_state == state && !mem_ready)
        wait_cnt <= wait_cnt + WCW'(1);
      else
        wait_cnt <= '0;
      if (next_state == S_FETCH && state != S_FETCH)
        instr_cnt <= instr_cnt + CNT_W'(1);
      if (state == S_DECODE && !d_legal) illegal <= 1'b1;
      if (timeout) bus_err <= 1'b1;
    end
  end

endmodule
